// File: rtl/dot_channel_feeder.sv
// dot_channel_feeder: sweeps one dot_channel through every weight set
// for a latched 288-element window and gathers the per-channel results.
module dot_channel_feeder #(
  parameter int CHANNELS = 16,
  parameter int TIMEOUT  = 64,
  parameter int DATA_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [288*DATA_LEN-1:0]      din,
  output logic                         busy,
  output logic                         load,
  output logic [3:0]                   cs,
  output logic [288*DATA_LEN-1:0]      d,
  input  logic                         valid_in,
  input  logic [DATA_LEN-1:0]          q_in,
  output logic                         out_valid,
  output logic [CHANNELS*DATA_LEN-1:0] out,
  output logic                         err
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [3:0]    CS_LAST = 4'(CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP1,
    GAP2,
    DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [3:0]                   cs_q, cs_d;
  logic [WW-1:0]                wd_q, wd_d;
  logic                         err_q, err_d;
  logic [288*DATA_LEN-1:0]      win_q, win_d;
  logic [CHANNELS*DATA_LEN-1:0] out_q, out_d;
  logic                         load_q, busy_q, ov_q;

  // State, datapath and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cs_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      win_q   <= '0;
      out_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      win_q   <= win_d;
      out_q   <= out_d;
      load_q  <= (state_d == LOAD);
      busy_q  <= (state_d != IDLE);
      ov_q    <= (state_d == DONE);
    end
  end

  // Next-state: accept, wait for valid or watchdog, two-cycle gap, finish
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    wd_d    = wd_q;
    err_d   = err_q;
    win_d   = win_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          win_d   = din;
          cs_d    = '0;
          err_d   = 1'b0;
          wd_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        wd_d = wd_q + 1'b1;
        if (valid_in) begin
          out_d[int'(cs_q)*DATA_LEN +: DATA_LEN] = q_in;
          state_d = GAP1;
        end else if (wd_q == WD_LAST) begin
          out_d[int'(cs_q)*DATA_LEN +: DATA_LEN] = '0;
          err_d   = 1'b1;
          state_d = GAP1;
        end
      end
      GAP1: state_d = GAP2;
      GAP2: begin
        if (cs_q == CS_LAST) begin
          state_d = DONE;
        end else begin
          cs_d    = cs_q + 1'b1;
          wd_d    = '0;
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign load      = load_q;
  assign cs        = cs_q;
  assign d         = win_q;
  assign out_valid = ov_q;
  assign out       = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dot_channel_feeder.sv
// tb_dot_channel_feeder: scoreboard bench with a dot_channel stand-in,
// plus a single-channel instance driven with start held high.
module tb_dot_channel_feeder;

  localparam int DL = 8;
  localparam int W  = 288 * DL;
  localparam int CH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] d0, d1;
  logic busy0, load0, valid0, ov0, err0;
  logic busy1, load1, valid1, ov1, err1;
  logic [3:0] cs0, cs1;
  logic [DL-1:0] q0, q1;
  logic [CH*DL-1:0] out0;
  logic [DL-1:0] out1;

  dot_channel_feeder #(.CHANNELS(CH), .TIMEOUT(64), .DATA_LEN(DL)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din),
    .busy(busy0), .load(load0), .cs(cs0), .d(d0),
    .valid_in(valid0), .q_in(q0), .out_valid(ov0), .out(out0), .err(err0)
  );

  dot_channel_feeder #(.CHANNELS(1), .TIMEOUT(16), .DATA_LEN(DL)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .din(din),
    .busy(busy1), .load(load1), .cs(cs1), .d(d1),
    .valid_in(valid1), .q_in(q1), .out_valid(ov1), .out(out1), .err(err1)
  );

  int cyc = 0;
  int pass_n = 0;
  int total_n = 0;

  // Cycle counter, read only on falling edges
  always @(posedge clk) cyc <= cyc + 1;

  // Channel stand-in: valid after 13 load-high cycles, optional stale hold
  int dead_cs = -1;
  int stale_n = 0;
  int lcnt = 0;
  int scnt = 0;
  logic vld_now;
  assign vld_now = load0 && (lcnt >= 13) && (int'(cs0) != dead_cs);
  assign valid0  = vld_now || (scnt > 0);
  assign q0      = 8'h10 + {4'h0, cs0};
  always @(posedge clk) begin
    lcnt <= load0 ? lcnt + 1 : 0;
    if (vld_now) scnt <= stale_n;
    else if (scnt > 0) scnt <= scnt - 1;
  end

  int lcnt1 = 0;
  assign valid1 = load1 && (lcnt1 >= 13);
  assign q1     = 8'h10 + {4'h0, cs1};
  // Stand-in for the single-channel instance
  always @(posedge clk) lcnt1 <= load1 ? lcnt1 + 1 : 0;

  task automatic check(input string n, input bit ok,
                       input logic [127:0] a, input logic [127:0] x);
    total_n++;
    if (ok) pass_n++;
    else $display("FAIL %s: got %h want %h", n, a, x);
  endtask

  typedef struct {
    logic [CH*DL-1:0] v;
    logic             e;
    int               at;
  } exp_t;
  exp_t sb[$];

  // Scoreboard monitor: every out_valid must match a queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ov0) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1'b0, 128'(ov0), 128'd0);
        end else begin
          e = sb.pop_front();
          check("out_vec", out0 == e.v, out0, e.v);
          check("err_at_done", err0 == e.e, 128'(err0), 128'(e.e));
          check("latency", cyc == e.at, 128'(cyc), 128'(e.at));
        end
      end
    end
  end

  // Load-pulse monitor: cs sequence, pulse length, two-cycle gap
  bit mon_en = 1'b1;
  initial begin
    bit pl;
    int ecs, lo, hi, pcs, dur;
    pl = 1'b0; ecs = 0; lo = 0; hi = 0; pcs = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (load0 && !pl) begin
          check("load_cs", cs0 == 4'(ecs), 128'(cs0), 128'(ecs));
          if (ecs > 0) check("gap_len", lo == 2, 128'(lo), 128'd2);
          ecs++; hi = 1; lo = 0; pcs = int'(cs0);
        end else if (load0) begin
          hi++;
        end else if (pl) begin
          dur = (pcs == dead_cs) ? 64 : 14;
          check("load_len", hi == dur, 128'(hi), 128'(dur));
          lo = 1;
        end else if (busy0) begin
          lo++;
        end
        if (ov0) check("pulse_count", ecs == CH, 128'(ecs), 128'(CH));
      end
      if (!busy0) ecs = 0;
      pl = load0;
    end
  end

  // Single-channel monitor: one pulse per sweep, fixed repeat period
  int n1 = 0;
  initial begin
    bit pl1;
    int np1, last1;
    pl1 = 1'b0; np1 = 0; last1 = -1;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (load1 && !pl1) np1++;
        if (ov1) begin
          check("c1_out", out1 == 8'h10, 128'(out1), 128'h10);
          check("c1_pulses", np1 == 1, 128'(np1), 128'd1);
          if (last1 >= 0)
            check("c1_period", cyc - last1 == 18, 128'(cyc - last1), 128'd18);
          last1 = cyc; np1 = 0; n1++;
        end
        pl1 = load1;
      end
    end
  end

  function automatic logic [W-1:0] pat(input logic [7:0] seed);
    logic [W-1:0] w;
    for (int i = 0; i < 288; i++) w[i*DL +: DL] = seed + 8'(i * 3);
    return w;
  endfunction

  task automatic run_start(input logic [W-1:0] w, input int dead,
                           input int stale);
    exp_t e;
    int lat;
    lat = 0;
    dead_cs = dead;
    stale_n = stale;
    @(negedge clk);
    start = 1'b1;
    din   = w;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < CH; k++) begin
      e.v[k*DL +: DL] = (k == dead) ? 8'h00 : 8'(16 + k);
      lat += ((k == dead) ? 64 : 14) + 2;
    end
    e.e  = (dead >= 0);
    e.at = cyc + lat;
    sb.push_back(e);
    check("busy_after_start", busy0 == 1'b1, 128'(busy0), 128'd1);
    check("load_after_start", load0 == 1'b1, 128'(load0), 128'd1);
    check("cs_after_start", cs0 == 4'd0, 128'(cs0), 128'd0);
    check("err_cleared", err0 == 1'b0, 128'(err0), 128'd0);
    check("d_latched", d0 == w, d0[127:0], w[127:0]);
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!ov0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ov0) check("out_valid_timeout", 1'b0, 128'(n), 128'd0);
  endtask

  initial begin
    logic [W-1:0] w1, w2;
    logic [CH*DL-1:0] full;
    int n;
    for (int k = 0; k < CH; k++) full[k*DL +: DL] = 8'(16 + k);
    w1 = pat(8'h21);
    w2 = pat(8'h9c);

    repeat (3) @(negedge clk);
    check("rst_load", load0 == 1'b0, 128'(load0), 128'd0);
    check("rst_busy", busy0 == 1'b0, 128'(busy0), 128'd0);
    check("rst_cs", cs0 == 4'd0, 128'(cs0), 128'd0);
    check("rst_ov", ov0 == 1'b0, 128'(ov0), 128'd0);
    check("rst_err", err0 == 1'b0, 128'(err0), 128'd0);
    check("rst_out", out0 == '0, out0, 128'd0);
    check("rst_d", d0 == '0, d0[127:0], 128'd0);
    rst_n = 1'b1;

    run_start(w1, -1, 0);
    repeat (20) @(negedge clk);
    start = 1'b1;
    din   = w2;
    @(negedge clk);
    start = 1'b0;
    check("d_hold_load", d0 == w1, d0[127:0], w1[127:0]);
    wait_ov();
    start = 1'b1;
    din   = w2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_done", busy0 == 1'b0, 128'(busy0), 128'd0);
    check("no_extra_load", load0 == 1'b0, 128'(load0), 128'd0);
    check("d_hold_done", d0 == w1, d0[127:0], w1[127:0]);
    check("out_hold", out0 == full, out0, full);

    run_start(pat(8'h05), 5, 0);
    wait_ov();
    repeat (5) @(negedge clk);
    check("err_sticky", err0 == 1'b1, 128'(err0), 128'd1);

    run_start(pat(8'h44), -1, 2);
    wait_ov();
    repeat (3) @(negedge clk);

    run_start(pat(8'h77), -1, 0);
    n = 0;
    while (!(load0 && cs0 == 4'd7) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_cs7", load0 && cs0 == 4'd7, 128'(cs0), 128'd7);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    check("mid_rst_load", load0 == 1'b0, 128'(load0), 128'd0);
    check("mid_rst_cs", cs0 == 4'd0, 128'(cs0), 128'd0);
    check("mid_rst_busy", busy0 == 1'b0, 128'(busy0), 128'd0);
    check("mid_rst_out", out0 == '0, out0, 128'd0);
    check("mid_rst_ov", ov0 == 1'b0, 128'(ov0), 128'd0);
    repeat (300) @(negedge clk);
    mon_en = 1'b1;

    run_start(pat(8'hd3), -1, 0);
    wait_ov();
    repeat (3) @(negedge clk);

    start1 = 1'b1;
    repeat (100) @(negedge clk);
    start1 = 1'b0;
    repeat (30) @(negedge clk);
    check("c1_sweeps", n1 >= 5, 128'(n1), 128'd5);
    check("sb_drained", sb.size() == 0, 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/dot_channel_feeder.md
# dot_channel_feeder

Drives one `dot_channel_15` instance through all of its weight sets for a single 288-element input window. It latches the window on `start`, then for each channel select asserts `load` with `cs`, waits for the channel's `valid`, and captures `q` into the matching result slot. Once every slot is filled it presents the whole vector with a one-cycle `out_valid`. It sits between the window/line-buffer stage and the layer output buffer.

## Interface
- `CHANNELS`, 16: number of weight sets swept; legal range 1..16, since `cs` is 4 bits.
- `TIMEOUT`, 64: maximum cycles spent in LOAD for one channel before the watchdog fires; must be ≥ 16.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request to process `din`; sampled only in IDLE.
- `din`  in  288*`data_len`  input window, latched when `start` is accepted.
- `busy`  out  1  high from the cycle after `start` is accepted through DONE.
- `load`  out  1  to `dot_channel.load`.
- `cs`  out  4  to `dot_channel.cs`; current channel index.
- `d`  out  288*`data_len`  to `dot_channel.d`; the latched window, stable throughout the sweep.
- `valid_in`  in  1  from `dot_channel.valid`.
- `q_in`  in  `data_len`  from `dot_channel.q`.
- `out_valid`  out  1  one-cycle pulse when `out` is complete.
- `out`  out  CHANNELS*`data_len`  result vector; slot k is at [k*`data_len` +: `data_len`].
- `err`  out  1  sticky watchdog flag; cleared when the next `start` is accepted.

## Operation
- FSM states: IDLE, LOAD, GAP1, GAP2, DONE.
- **IDLE**
  - `load`=0 and `busy`=0.
  - When `start`=1: latch `din` into the window register, set `cs`=0, clear `err`, clear the watchdog counter, go to LOAD.
- **LOAD**
  - `load`=1; the watchdog counter increments each cycle.
  - When `valid_in`=1: write `q_in` into slot `cs`, go to GAP1.
  - When the counter reaches TIMEOUT-1 with `valid_in`=0: write zero into slot `cs`, set `err`=1, go to GAP1.
  - If both happen in the same cycle, `valid_in` wins and `err` is not set.
- **GAP1, GAP2**
  - `load`=0 and `valid_in` is ignored. The two-cycle gap lets the channel's `valid` fall and guarantees the 0→1 `load` edge that re-initialises the channel.
  - On leaving GAP2: if `cs`==CHANNELS-1, go to DONE. Otherwise `cs`←`cs`+1, clear the watchdog, go to LOAD.
- **DONE**
  - `out_valid`=1 for this cycle only, then go to IDLE.
  - `out` holds its value until the next accepted `start` begins overwriting slots.
- `start` outside IDLE, including during the DONE cycle, is ignored and not queued.
- `d` is a direct register output; `din` may change freely after the accepting edge.
- Slots not yet written in the current sweep keep the previous sweep's values until overwritten.

## Timing
- All outputs are registered.
- Reset values (synchronous, `rst_n`=0 at an edge):
  - state IDLE
  - `load`=0, `cs`=0, `busy`=0, `out_valid`=0, `err`=0
  - `out`=0, window register=0, watchdog=0
- Reset mid-sweep: `load` drops at that edge and no `out_valid` is produced. The first `start` sampled with `rst_n`=1 in IDLE begins a fresh sweep.
- `start` sampled at edge t0 → `load`=1, `cs`=0, `busy`=1 visible after t0.
- If `valid_in` is sampled high at edge t:
  - `out[cs]` is updated at t.
  - `load`=0 after t.
  - `load`=1 with `cs`+1 after t+2.
- Per-channel period is L+3 cycles, where L is the number of LOAD cycles until `valid_in` is seen; L≈13 for `dot_channel_15`.
- Total from `start` to `out_valid` is CHANNELS·(L+3)+1 cycles.
- `busy` falls in the cycle after DONE, so back-to-back `start` can be accepted every CHANNELS·(L+3)+2 cycles.

## Test plan
- **Normal sweep.** Use a consumer model with L=13 and q=0x10+cs, then one `start`.
  - Required: 16 `load` pulses with `cs` 0..15, each followed by `load` low for exactly 2 cycles.
  - Required: `out_valid` once, 257 cycles after `start`; slot k=0x10+k; `err`=0.
- **Ignored start.** Pulse `start` with a different `din` during LOAD and again during DONE.
  - Required: `d` unchanged, no extra sweep, `out` unchanged.
- **Watchdog.** The model never raises `valid` for cs=5, TIMEOUT=64.
  - Required: cs=5 `load` lasts 64 cycles, slot 5=0, `err`=1 sticky, remaining channels complete normally.
  - Required: `err` clears on the next accepted `start`.
- **Stale valid.** The model holds `valid` high for 2 extra cycles after `load` falls.
  - Required: no double capture, `cs` advances by exactly one, slot values correct.
- **Reset mid-sweep.** Assert `rst_n`=0 for 1 cycle while cs=7 is in LOAD.
  - Required: next cycle `load`=0, `cs`=0, `busy`=0, `out`=0, no `out_valid`.
  - Required: a subsequent `start` completes a full correct sweep.
- **CHANNELS=1, back-to-back start.** Hold `start` high continuously.
  - Required: each sweep is one `load` pulse then `out_valid`; sweeps repeat every L+5 cycles.
